// File: rtl/wb_ram_slave.sv
// Wishbone B3 classic slave terminating a 32-bit master in a byte-laned on-chip RAM.
// Latency: ack WAIT_STATES+1 edges after the request is first sampled; err after one edge.
// Backpressure: master waits for ack/err; dropping cyc/stb during the wait aborts with no side effects.
//
// Ports:
//   wb_clk_i, wb_rst_i    clock, async active-low reset
//   wb_addr_i, wb_data_i  byte address (bits [1:0] ignored), write data
//   wb_sel_i, wb_we_i     byte lane enables, write strobe
//   wb_cyc_i, wb_stb_i    cycle / strobe
//   wb_data_o             read data, held until the next read completes
//   wb_ack_o, wb_err_o    registered one-cycle terminations
//   wb_rty_o              tied low
module wb_ram_slave #(
   parameter int          AW          = 6,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_addr_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] wb_data_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // Counter value loaded on entry to WAIT; WAIT is never entered when WAIT_STATES is 0.
   localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t         state, state_nxt;
   logic [2:0]     cnt, cnt_nxt;
   logic           req;
   logic           hit;
   logic [AW-1:0]  word_idx;
   logic           enter_ack;
   logic [31:0]    rd_dat;
   logic [31:0]    mem [0:(1<<AW)-1];

   // Byte-offset bits carry no information for a word-wide RAM.
   logic           unused_addr_lsb;
   assign unused_addr_lsb = ^wb_addr_i[1:0];

   assign req      = wb_cyc_i & wb_stb_i;
   assign hit      = (wb_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign word_idx = wb_addr_i[AW+1:2];

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state <= ST_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // enter_ack marks the single edge where the access actually takes effect,
   // so aborted or errored requests never touch the RAM or the read register.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      enter_ack = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (!hit || (wb_sel_i == 4'h0)) begin
                  state_nxt = ST_ERR;
               end else if (WAIT_STATES == 0) begin
                  state_nxt = ST_ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = 3'd0;
            end else if (cnt == 3'd0) begin
               state_nxt = ST_ACK;
               enter_ack = 1'b1;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         ST_ACK:  state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // RAM has no reset: contents survive wb_rst_i. A write pending in WAIT is
   // dropped because reset forces the FSM back to IDLE before ACK can be entered.
   always_ff @(posedge wb_clk_i) begin
      if (enter_ack && wb_we_i) begin
         for (int n = 0; n < 4; n++) begin
            if (wb_sel_i[n]) begin
               mem[word_idx][8*n +: 8] <= wb_data_i[8*n +: 8];
            end
         end
      end
   end

   // Reads return the whole word regardless of wb_sel_i.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         rd_dat <= 32'h0;
      end else if (enter_ack && !wb_we_i) begin
         rd_dat <= mem[word_idx];
      end
   end

   // Terminations decode directly from the state register, so they are glitch-free
   // and mutually exclusive by construction.
   assign wb_ack_o  = (state == ST_ACK);
   assign wb_err_o  = (state == ST_ERR);
   assign wb_rty_o  = 1'b0;
   assign wb_data_o = rd_dat;

endmodule

// File: tb/tb_wb_ram_slave.sv
module tb_wb_ram_slave;

   logic        clk;
   logic        rst_n [2];
   logic [31:0] adr   [2];
   logic [31:0] dat_i [2];
   logic [31:0] dat_o [2];
   logic [3:0]  sel   [2];
   logic        we    [2];
   logic        cyc   [2];
   logic        stb   [2];
   logic        ack   [2];
   logic        err   [2];
   logic        rty   [2];

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: one wait state. Instance 1: three wait states.
   wb_ram_slave #(.AW(6), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut1 (
      .wb_clk_i (clk),      .wb_rst_i (rst_n[0]),
      .wb_addr_i(adr[0]),   .wb_data_i(dat_i[0]), .wb_data_o(dat_o[0]),
      .wb_sel_i (sel[0]),   .wb_we_i  (we[0]),
      .wb_cyc_i (cyc[0]),   .wb_stb_i (stb[0]),
      .wb_ack_o (ack[0]),   .wb_err_o (err[0]),   .wb_rty_o (rty[0])
   );

   wb_ram_slave #(.AW(6), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
      .wb_clk_i (clk),      .wb_rst_i (rst_n[1]),
      .wb_addr_i(adr[1]),   .wb_data_i(dat_i[1]), .wb_data_o(dat_o[1]),
      .wb_sel_i (sel[1]),   .wb_we_i  (we[1]),
      .wb_cyc_i (cyc[1]),   .wb_stb_i (stb[1]),
      .wb_ack_o (ack[1]),   .wb_err_o (err[1]),   .wb_rty_o (rty[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {ack, err} packed for compact termination checks: 2 = ack, 1 = err, 0 = none.
   function automatic logic [31:0] term(input int d);
      return {30'b0, ack[d], err[d]};
   endfunction

   task automatic drive(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
      adr[d] = a;    dat_i[d] = wd; sel[d] = s;
   endtask

   task automatic idle_bus(input int d);
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
   endtask

   // One complete transfer: request is driven at a negedge so the following
   // posedge is E1; outputs are sampled on negedges after each edge.
   task automatic xfer(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s, input int ws,
                       input bit is_err, input bit chk_rd, input logic [31:0] exp_rd,
                       input string tag);
      int lat;
      @(negedge clk);
      drive(d, w, a, wd, s);
      lat = is_err ? 0 : ws;
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         check({tag, "_wait"}, term(d), 32'd0);
      end
      @(negedge clk);
      check({tag, "_term"}, term(d), is_err ? 32'd1 : 32'd2);
      if (chk_rd) check({tag, "_rdat"}, dat_o[d], exp_rd);
      idle_bus(d);
      @(negedge clk);
      check({tag, "_end"}, term(d), 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         adr[d] = 32'h0; dat_i[d] = 32'h0; sel[d] = 4'h0;
         idle_bus(d);
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_term", term(d), 32'd0);
         check("rst_rty",  {31'b0, rty[d]}, 32'd0);
         check("rst_dato", dat_o[d], 32'h0);
      end
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      // Basic writes/reads with one wait state.
      xfer(0, 1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 1, 0, 0, 32'h0, "wr_w0");
      xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 32'h0, "wr_10");
      xfer(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1, 0, 1, 32'hDEAD_BEEF, "rd_10");

      // Single-lane write merges into the existing word.
      xfer(0, 1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, 1, 0, 0, 32'h0, "wr_lane1");
      xfer(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF,    1, 0, 1, 32'hDEAD_AAEF, "rd_merge");
      xfer(0, 1'b0, 32'h0000_0010, 32'h0,         4'b0001, 1, 0, 1, 32'hDEAD_AAEF, "rd_sel1");
      xfer(0, 1'b0, 32'h0000_0013, 32'h0,         4'hF,    1, 0, 1, 32'hDEAD_AAEF, "rd_lsb_ign");

      // Out-of-window and zero-select requests terminate with err, touching nothing.
      xfer(0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 1, 1, 1, 32'hDEAD_AAEF, "err_miss");
      xfer(0, 1'b1, 32'h0000_0010, 32'h5555_5555, 4'h0, 1, 1, 1, 32'hDEAD_AAEF, "err_sel0");
      xfer(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1, 0, 1, 32'hDEAD_AAEF, "rd_after_err");

      // Three wait states: abort before ack leaves the word untouched.
      xfer(1, 1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 4'hF, 3, 0, 0, 32'h0, "w3_wr20");
      @(negedge clk);
      drive(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
      repeat (2) begin
         @(negedge clk);
         check("abort_wait", term(1), 32'd0);
      end
      idle_bus(1);
      repeat (4) begin
         @(negedge clk);
         check("abort_after", term(1), 32'd0);
      end
      xfer(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 3, 0, 1, 32'h0BAD_CAFE, "w3_rd20");

      // Reset mid-WAIT: outputs clear at once, pending write is lost, RAM survives.
      @(negedge clk);
      drive(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF);
      @(negedge clk);
      check("rst_pre_wait", term(0), 32'd0);
      rst_n[0] = 1'b0;
      #1;
      check("rstw_term", term(0), 32'd0);
      check("rstw_rty",  {31'b0, rty[0]}, 32'd0);
      check("rstw_dato", dat_o[0], 32'h0);
      idle_bus(0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rstw_noack", term(0), 32'd0);
      end
      xfer(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 0, 1, 32'hDEAD_AAEF, "rd_post_rst");

      // Top word does not alias onto word 0.
      xfer(0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 32'h0, "wr_top");
      xfer(0, 1'b0, 32'h0000_00FC, 32'h0, 4'hF, 1, 0, 1, 32'hCAFE_F00D, "rd_top");
      xfer(0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 1, 0, 1, 32'h0102_0304, "rd_w0");

      // Request held past ack: one transfer every WAIT_STATES+2 = 3 cycles.
      @(negedge clk);
      drive(0, 1'b0, 32'h0000_00FC, 32'h0, 4'hF);
      begin
         logic [5:0] pat;
         pat = 6'b010010;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("b2b_k%0d", k), {31'b0, ack[0]}, {31'b0, pat[5-k]});
         end
      end
      idle_bus(0);
      @(negedge clk);
      check("b2b_end", term(0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone B3 classic slave that terminates the 32-bit master port of the asynchronous memory bridge in a byte-laned on-chip RAM. It decodes a base window, generates registered ack/err with a programmable wait-state count, applies byte selects on writes, and handles aborted cycles. This block replaces the bare RAM instances on the bridge's Wishbone side and supplies the handshake they lack.

## Interface
- AW, 6, word-address bits; RAM depth is 2^AW 32-bit words, window size 2^(AW+2) bytes
- BASE_ADDR, 32'h0000_0000, byte base of window; must be aligned to window size
- WAIT_STATES, 1, extra cycles before ack, 0..7
- wb_clk_i  in  1  system clock; all state updates on rising edge
- wb_rst_i  in  1  reset, asynchronous assert, active-low (0 = reset)
- wb_addr_i  in  32  byte address; bits [1:0] ignored
- wb_data_i  in  32  write data from master
- wb_data_o  out  32  read data to master
- wb_sel_i  in  4  byte lane enables; bit n covers [8n+7:8n]
- wb_we_i  in  1  1 = write, 0 = read
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- wb_rty_o  out  1  retry; constant 0

## Operation
- Request = wb_cyc_i & wb_stb_i. Hit = wb_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]. Word index = wb_addr_i[AW+1:2].
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE: on request with (!hit or wb_sel_i == 0) -> ERR. On request with hit: WAIT_STATES == 0 -> ACK, else WAIT with counter = WAIT_STATES-1. No request -> IDLE.
- WAIT: request dropped -> IDLE (abort: no write, no ack, wb_data_o unchanged). Counter == 0 -> ACK, else decrement.
- ACK: wb_ack_o = 1 for exactly this cycle; -> IDLE unconditionally.
- ERR: wb_err_o = 1 for exactly this cycle; -> IDLE unconditionally.
- Write: on the edge entering ACK, each lane with wb_sel_i[n] = 1 is written from wb_data_i; other lanes keep their value.
- Read: on the edge entering ACK, wb_data_o loads the full 32-bit word regardless of wb_sel_i; holds until the next read's ACK entry. Writes and errors leave wb_data_o unchanged.
- ack and err never assert together; at most one termination per request.
- Address and control are sampled at the edge entering ACK/ERR; the master must hold them stable while the request is present.
- RAM contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset (wb_rst_i = 0, any time, including mid-WAIT): state IDLE, counter 0, wb_ack_o = 0, wb_err_o = 0, wb_rty_o = 0, wb_data_o = 0. Any pending write is dropped. RAM keeps its contents.
- E1 is the first rising edge that samples a request in IDLE.
- Hit: wb_ack_o rises at E1+WAIT_STATES and falls at the next edge.
- Miss or sel = 0: wb_err_o rises at E1 and falls at E1+1, independent of WAIT_STATES.
- The edge that ends ACK/ERR returns to IDLE; the next request is sampled no earlier than the following edge. A master holding stb past ack starts a second transfer.
- Throughput: one transfer per WAIT_STATES+2 cycles.
- Addresses differing only in [1:0] map to the same word; the top word (index 2^AW-1) does not wrap into the window.

## Test plan
- WAIT_STATES=1: write 0xDEADBEEF to 0x0000_0010 with sel 4'hF, E1 = first edge sampling the request -> ack high E1+1 to E1+2 only. Read 0x0000_0010 -> ack at E1+1, wb_data_o = 0xDEADBEEF.
- Write 0x0000_AA00 to 0x0000_0010 with sel 4'b0010, then read -> 0xDEADAAEF. Read with sel 4'b0001 -> full word 0xDEADAAEF.
- AW=6, base 0: write to 0x0000_0100 -> err high E1 to E1+1 only, no ack, RAM and wb_data_o unchanged. Request with sel 4'h0 at 0x0000_0010 -> err.
- WAIT_STATES=3: write 0x12345678 to 0x0000_0020, drop stb before E1+3 -> no ack/err. Read 0x0000_0020 -> prior value.
- Pulse wb_rst_i low during WAIT -> all outputs 0 immediately, no ack follows. After release, read of earlier-written 0x0000_0010 -> 0xDEADAAEF.
- Write 0xCAFEF00D to 0x0000_00FC (top word), read 0x0000_00FC and 0x0000_0000 -> 0xCAFEF00D; 0x0000_0000 returns its prior value. Back-to-back requests -> accepted one per WAIT_STATES+2 cycles.
